// File: rtl/multiply_iteration.sv
// Radix-2 shift-add multiplier: rebuilds a = round(c * b) from I8F8 c and I8 b, one bit of b/cycle.
// Define MULTIPLY_ITERATION_SAT_EN to saturate dat_a_o at 8'hFF on overflow (default: wrap).
module multiply_iteration #(
    parameter int unsigned DATA_WD     = 8,
    parameter int unsigned DATA_FRA_WD = 8,
    parameter int unsigned NUMB_ITR    = DATA_WD,
    parameter int unsigned NUMB_ITR_WD = $clog2(NUMB_ITR),
    parameter int unsigned ACC_WD      = 2 * DATA_WD + DATA_FRA_WD
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           val_i,
    input  logic [DATA_WD+DATA_FRA_WD-1:0] dat_c_i,
    input  logic [DATA_WD-1:0]             dat_b_i,
    output logic                           rdy_o,
    output logic                           val_o,
    output logic [DATA_WD-1:0]             dat_a_o,
    output logic                           ovf_o
);

    localparam int unsigned C_WD    = DATA_WD + DATA_FRA_WD;
    localparam int unsigned FULL_WD = ACC_WD - DATA_FRA_WD;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_t;

    state_t                 state_r;
    logic [C_WD-1:0]        c_r;
    logic [DATA_WD-1:0]     b_r;
    logic [ACC_WD-1:0]      acc_r;
    logic [NUMB_ITR_WD-1:0] cnt_r;

    logic [ACC_WD-1:0]      addend;
    logic [ACC_WD-1:0]      acc_next;
    logic [FULL_WD-1:0]     full;
    logic                   ovf_next;
    logic [DATA_WD-1:0]     dat_a_next;

    always_comb begin
        addend   = b_r[cnt_r] ? (ACC_WD'(c_r) << cnt_r) : '0;
        acc_next = acc_r + addend;
        // Round half-up, then drop the fraction bits.
        full     = FULL_WD'((acc_next + (ACC_WD'(1) << (DATA_FRA_WD - 1))) >> DATA_FRA_WD);
        ovf_next = |full[FULL_WD-1:DATA_WD];
`ifdef MULTIPLY_ITERATION_SAT_EN
        dat_a_next = ovf_next ? '1 : full[DATA_WD-1:0];
`else
        dat_a_next = full[DATA_WD-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= StIdle;
            c_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            cnt_r   <= '0;
            rdy_o   <= 1'b1;
            val_o   <= 1'b0;
            dat_a_o <= '0;
            ovf_o   <= 1'b0;
        end else begin
            val_o <= 1'b0;
            unique case (state_r)
                StIdle: begin
                    if (val_i) begin
                        c_r     <= dat_c_i;
                        b_r     <= dat_b_i;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        rdy_o   <= 1'b0;
                        state_r <= StBusy;
                    end
                end
                StBusy: begin
                    acc_r <= acc_next;
                    if (cnt_r == NUMB_ITR_WD'(NUMB_ITR - 1)) begin
                        cnt_r   <= '0;
                        val_o   <= 1'b1;
                        dat_a_o <= dat_a_next;
                        ovf_o   <= ovf_next;
                        state_r <= StDone;
                    end else begin
                        cnt_r <= cnt_r + NUMB_ITR_WD'(1);
                    end
                end
                StDone: begin
                    rdy_o   <= 1'b1;
                    state_r <= StIdle;
                end
                default: begin
                    rdy_o   <= 1'b1;
                    state_r <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_iteration.sv
// Scoreboard bench for multiply_iteration: directed vectors, queue-based monitor checking result,
// overflow flag and strobe latency.
module tb_multiply_iteration;

    logic        clk;
    logic        rstn;
    logic        val_i;
    logic [15:0] dat_c_i;
    logic [7:0]  dat_b_i;
    logic        rdy_o;
    logic        val_o;
    logic [7:0]  dat_a_o;
    logic        ovf_o;

    multiply_iteration dut (
        .clk     (clk),
        .rstn    (rstn),
        .val_i   (val_i),
        .dat_c_i (dat_c_i),
        .dat_b_i (dat_b_i),
        .rdy_o   (rdy_o),
        .val_o   (val_o),
        .dat_a_o (dat_a_o),
        .ovf_o   (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_pulse = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per result strobe.
    always @(negedge clk) begin
        if (val_o) begin
            exp_t e;
            n_pulse++;
            if (sb.size() == 0) begin
                chk("unexpected_val_o", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("dat_a_o", int'(dat_a_o), int'(e.a));
                chk("ovf_o", int'(ovf_o), int'(e.ovf));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    // Issue one op; k returns the cycle stamp of the accept edge.
    task automatic send(input logic [15:0] c, input logic [7:0] b, input logic [7:0] ea,
                        input logic eovf, input bit push, output int k);
        int t;
        t = 0;
        @(negedge clk);
        while (!rdy_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!rdy_o) chk("rdy_timeout", 0, 1);
        dat_c_i = c;
        dat_b_i = b;
        val_i   = 1'b1;
        @(negedge clk);
        val_i = 1'b0;
        k     = cyc;
        if (push) sb.push_back('{a: ea, ovf: eovf, cyc: k + 8});
    endtask

    localparam int NV = 9;
    logic [15:0] vc [NV];
    logic [7:0]  vb [NV];
    logic [7:0]  va [NV];
    logic        vo [NV];

    initial begin
        int k;
        int p0;
        int t;

        vc[0] = 16'h0055; vb[0] = 8'h03; va[0] = 8'h01; vo[0] = 1'b0;
        vc[1] = 16'h0000; vb[1] = 8'h55; va[1] = 8'h00; vo[1] = 1'b0;
        vc[2] = 16'h1234; vb[2] = 8'h00; va[2] = 8'h00; vo[2] = 1'b0;
        vc[3] = 16'h0080; vb[3] = 8'h01; va[3] = 8'h01; vo[3] = 1'b0;
        vc[4] = 16'h007F; vb[4] = 8'h01; va[4] = 8'h00; vo[4] = 1'b0;
        vc[5] = 16'h0100; vb[5] = 8'hFF; va[5] = 8'hFF; vo[5] = 1'b0;
        vc[6] = 16'hFFFF; vb[6] = 8'hFF; va[6] = 8'hFF; vo[6] = 1'b1;
`ifdef MULTIPLY_ITERATION_SAT_EN
        vc[7] = 16'h2000; vb[7] = 8'h0A; va[7] = 8'hFF; vo[7] = 1'b1;
        vc[8] = 16'h0180; vb[8] = 8'hAB; va[8] = 8'hFF; vo[8] = 1'b1;
`else
        vc[7] = 16'h2000; vb[7] = 8'h0A; va[7] = 8'h40; vo[7] = 1'b1;
        vc[8] = 16'h0180; vb[8] = 8'hAB; va[8] = 8'h01; vo[8] = 1'b1;
`endif

        rstn    = 1'b0;
        val_i   = 1'b0;
        dat_c_i = '0;
        dat_b_i = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_rdy_o", int'(rdy_o), 1);
        chk("reset_val_o", int'(val_o), 0);
        chk("reset_dat_a_o", int'(dat_a_o), 0);
        chk("reset_ovf_o", int'(ovf_o), 0);

        // 1.5 * 3 = 4.5 -> 5, with busy window on rdy_o.
        send(16'h0180, 8'h03, 8'd5, 1'b0, 1'b1, k);
        for (int i = 0; i < 9; i++) begin
            chk("rdy_o_busy", int'(rdy_o), 0);
            @(negedge clk);
        end
        chk("rdy_o_after_done", int'(rdy_o), 1);

        for (int i = 0; i < NV; i++) send(vc[i], vb[i], va[i], vo[i], 1'b1, k);

        // val_i held high through BUSY/DONE: second op accepted only at E10.
        t = 0;
        @(negedge clk);
        while (!rdy_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        p0      = n_pulse;
        dat_c_i = 16'h0180;
        dat_b_i = 8'h03;
        val_i   = 1'b1;
        @(negedge clk);
        k       = cyc;
        dat_c_i = 16'h0200;
        dat_b_i = 8'h02;
        sb.push_back('{a: 8'd5, ovf: 1'b0, cyc: k + 8});
        sb.push_back('{a: 8'd4, ovf: 1'b0, cyc: k + 18});
        repeat (10) @(negedge clk);
        val_i = 1'b0;
        repeat (12) @(negedge clk);
        chk("b2b_pulse_count", n_pulse - p0, 2);

        // Reset mid-operation discards the op.
        send(16'h0100, 8'h07, 8'd0, 1'b0, 1'b0, k);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_dat_a_o", int'(dat_a_o), 0);
        chk("midrst_ovf_o", int'(ovf_o), 0);
        chk("midrst_rdy_o", int'(rdy_o), 1);
        chk("midrst_val_o", int'(val_o), 0);
        @(negedge clk);
        rstn = 1'b1;
        p0   = n_pulse;
        repeat (15) @(negedge clk);
        chk("midrst_no_pulse", n_pulse - p0, 0);
        chk("midrst_idle_rdy_o", int'(rdy_o), 1);
        chk("midrst_hold_dat_a_o", int'(dat_a_o), 0);
        send(16'h0100, 8'h07, 8'd7, 1'b0, 1'b1, k);

        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
